// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Holds the FSM state enum, default width and counter width helper.
package div_pkg;

   localparam int DIV_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      FIX
   } state_t;

   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

   localparam int CNT_W = cnt_w(DIV_W);

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of the sequential divider.
// master: start, dvd, dvs out; quot, rem, busy, done, dbz, ovf in.
interface seq_divider_if
   import div_pkg::*;
#(
   parameter int W = DIV_W
);

   logic           start;
   logic [2*W-1:0] dvd;
   logic [W-1:0]   dvs;
   logic [W-1:0]   quot;
   logic [W-1:0]   rem;
   logic           busy;
   logic           done;
   logic           dbz;
   logic           ovf;

   modport master (
      output start, dvd, dvs,
      input  quot, rem, busy, done, dbz, ovf
   );

   modport slave (
      input  start, dvd, dvs,
      output quot, rem, busy, done, dbz, ovf
   );

endinterface

// File: rtl/div_addsub.sv
// Trial subtractor for the restoring divider: diff = a - b.
// Ports: a, b (N bits) in; diff (N bits), neg (borrow) out.
module div_addsub
   import div_pkg::*;
#(
   parameter int N = DIV_W + 1
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         neg
);

   assign {neg, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, 2W/W -> W quotient + W remainder.
// Ports: clk, rst_n (async low), bus (slave): start/dvd/dvs in;
// quot/rem/busy/done/dbz/ovf out. DIVIDER_SIGNED_EN: signed ops.
module seq_divider
   import div_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic       clk,
   input  logic       rst_n,
   seq_divider_if.slave bus
);

   localparam int CW = cnt_w(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);
`ifdef DIVIDER_SIGNED_EN
   localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] NEG_MAX = {1'b1, {(W-1){1'b0}}};
`endif

   state_t         state, state_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [2*W-1:0] rq, rq_n;
   logic [W-1:0]   dm, dm_n;
   logic           qs, qs_n;
   logic           rs, rs_n;
   logic           ez, ez_n;
   logic           eo, eo_n;
   logic [W-1:0]   quot, quot_n;
   logic [W-1:0]   rem, rem_n;
   logic           busy, busy_n;
   logic           done, done_n;
   logic           dbz, dbz_n;
   logic           ovf, ovf_n;

   logic [2*W-1:0] amag;
   logic [W-1:0]   bmag;
   logic           qsg, rsg;
   logic [W:0]     diff;
   logic           neg;
   logic           keep;
   logic [W-1:0]   qmag, rmag;
   logic           rng;

   // upper W+1 bits of the partial remainder after the left shift
   div_addsub #(.N(W + 1)) u_sub (
      .a    (rq[2*W-1:W-1]),
      .b    ({1'b0, dm}),
      .diff (diff),
      .neg  (neg)
   );

   always_comb begin
`ifdef DIVIDER_SIGNED_EN
      qsg  = bus.dvd[2*W-1] ^ bus.dvs[W-1];
      rsg  = bus.dvd[2*W-1];
      amag = bus.dvd[2*W-1] ? -bus.dvd : bus.dvd;
      bmag = bus.dvs[W-1] ? -bus.dvs : bus.dvs;
`else
      qsg  = 1'b0;
      rsg  = 1'b0;
      amag = bus.dvd;
      bmag = bus.dvs;
`endif
      qmag = rq[W-1:0];
      rmag = rq[2*W-1:W];
`ifdef DIVIDER_SIGNED_EN
      rng  = qs ? (qmag > NEG_MAX) : (qmag > POS_MAX);
`else
      rng  = 1'b0;
`endif
      // a kept difference is below the divisor, so diff[W] is 0
      keep = ~neg & ~diff[W];
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rq_n    = rq;
      dm_n    = dm;
      qs_n    = qs;
      rs_n    = rs;
      ez_n    = ez;
      eo_n    = eo;
      quot_n  = quot;
      rem_n   = rem;
      busy_n  = busy;
      done_n  = 1'b0;
      dbz_n   = dbz;
      ovf_n   = ovf;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               rq_n   = amag;
               dm_n   = bmag;
               qs_n   = qsg;
               rs_n   = rsg;
               cnt_n  = '0;
               dbz_n  = 1'b0;
               ovf_n  = 1'b0;
               busy_n = 1'b1;
               ez_n   = (bus.dvs == '0);
               // high half >= divisor means quotient >= 2^W
               eo_n   = (bus.dvs != '0) &&
                        (amag[2*W-1:W] >= bmag);
               state_n = (ez_n | eo_n) ? FIX : ITER;
            end
         end
         ITER: begin
            if (keep)
               rq_n = {diff[W-1:0], rq[W-2:0], 1'b1};
            else
               rq_n = {rq[2*W-2:0], 1'b0};
            cnt_n = cnt + CW'(1);
            if (cnt == LAST)
               state_n = FIX;
         end
         FIX: begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
            dbz_n   = ez;
            ovf_n   = eo | (rng & ~ez);
            if (ez | eo | rng) begin
               quot_n = '0;
               rem_n  = '0;
            end else begin
               quot_n = qs ? -qmag : qmag;
               rem_n  = rs ? -rmag : rmag;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         rq    <= '0;
         dm    <= '0;
         qs    <= 1'b0;
         rs    <= 1'b0;
         ez    <= 1'b0;
         eo    <= 1'b0;
         quot  <= '0;
         rem   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         dbz   <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         rq    <= rq_n;
         dm    <= dm_n;
         qs    <= qs_n;
         rs    <= rs_n;
         ez    <= ez_n;
         eo    <= eo_n;
         quot  <= quot_n;
         rem   <= rem_n;
         busy  <= busy_n;
         done  <= done_n;
         dbz   <= dbz_n;
         ovf   <= ovf_n;
      end
   end

   assign bus.quot = quot;
   assign bus.rem  = rem;
   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.dbz  = dbz;
   assign bus.ovf  = ovf;

endmodule
